// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter and related monitors.
package clk_period_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEAS = 2'd1,
      ST_TOUT = 2'd2
   } meter_state_t;

   localparam int unsigned CNT_W_DEF    = 16;
   localparam int unsigned LOCK_CNT_DEF = 4;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer plus registered rise/fall pulses and the matching level.
// Edges are suppressed until the pipeline holds real samples after reset.
module sync_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic       r_rise;
   logic       r_fall;
   logic [2:0] r_fill;

   // A level already high at reset release must not look like a rising edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_fill  <= 3'b000;
      end else begin
         r_sync1 <= i_sig;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_fill  <= {r_fill[1:0], 1'b1};
         r_rise  <= r_sync2 & ~r_prev & r_fill[2];
         r_fall  <= ~r_sync2 & r_prev & r_fill[2];
      end
   end

   assign o_level = r_prev;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a sampled signal in Clk_in cycles,
// flags lock on repeated equal periods and timeout on a stalled input.
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic             Clk_in,
   input  logic             Reset,
   input  logic             Sig_in,
   output logic [CNT_W-1:0] Period,
   output logic [CNT_W-1:0] High_time,
   output logic             Valid,
   output logic             L,
   output logic             Timeout
);

   localparam int unsigned      MC_W       = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;
   localparam logic [MC_W-1:0]  MC_LOCK    = MC_W'(LOCK_CNT);
   localparam logic [MC_W-1:0]  MC_LOCK_M1 = MC_W'(LOCK_CNT - 1);

   logic w_level;
   logic w_rise;
   logic w_fall;

   meter_state_t     r_state,     w_state_nxt;
   logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
   logic [CNT_W-1:0] r_hcnt,      w_hcnt_nxt;
   logic [CNT_W-1:0] r_period,    w_period_nxt;
   logic [CNT_W-1:0] r_high,      w_high_nxt;
   logic [CNT_W-1:0] r_prev_per,  w_prev_per_nxt;
   logic             r_have_prev, w_have_prev_nxt;
   logic [MC_W-1:0]  r_mcnt,      w_mcnt_nxt;
   logic             r_valid,     w_valid_nxt;
   logic             r_lock,      w_lock_nxt;
   logic             r_timeout,   w_timeout_nxt;

   sync_edge_det u_sync_edge_det (
      .i_clk   (Clk_in),
      .i_rst   (Reset),
      .i_sig   (Sig_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_hcnt      <= '0;
         r_period    <= '0;
         r_high      <= '0;
         r_prev_per  <= '0;
         r_have_prev <= 1'b0;
         r_mcnt      <= '0;
         r_valid     <= 1'b0;
         r_lock      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hcnt      <= w_hcnt_nxt;
         r_period    <= w_period_nxt;
         r_high      <= w_high_nxt;
         r_prev_per  <= w_prev_per_nxt;
         r_have_prev <= w_have_prev_nxt;
         r_mcnt      <= w_mcnt_nxt;
         r_valid     <= w_valid_nxt;
         r_lock      <= w_lock_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   // Next-state, counters and lock tracking
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_hcnt_nxt      = r_hcnt;
      w_period_nxt    = r_period;
      w_high_nxt      = r_high;
      w_prev_per_nxt  = r_prev_per;
      w_have_prev_nxt = r_have_prev;
      w_mcnt_nxt      = r_mcnt;
      w_valid_nxt     = 1'b0;
      w_lock_nxt      = r_lock;
      w_timeout_nxt   = r_timeout;

      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_cnt_nxt   = CNT_ONE;
               w_hcnt_nxt  = CNT_ONE;
               w_state_nxt = ST_MEAS;
            end
         end

         ST_MEAS: begin
            if (w_rise) begin
               w_period_nxt    = r_cnt;
               w_valid_nxt     = 1'b1;
               w_cnt_nxt       = CNT_ONE;
               w_hcnt_nxt      = CNT_ONE;
               w_prev_per_nxt  = r_cnt;
               w_have_prev_nxt = 1'b1;
               // First period after IDLE/TOUT only primes the comparison
               if (r_have_prev) begin
                  if (r_cnt == r_prev_per) begin
                     if (r_mcnt != MC_LOCK) begin
                        w_mcnt_nxt = r_mcnt + MC_W'(1);
                     end
                     w_lock_nxt = (r_mcnt >= MC_LOCK_M1);
                  end else begin
                     w_mcnt_nxt = '0;
                     w_lock_nxt = 1'b0;
                  end
               end
            end else begin
               if (w_fall) begin
                  w_high_nxt = r_hcnt;
               end
               if (w_level && (r_hcnt != CNT_MAX)) begin
                  w_hcnt_nxt = r_hcnt + CNT_ONE;
               end
               if (r_cnt != CNT_MAX) begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
               if (r_cnt == CNT_MAX_M1) begin
                  w_state_nxt     = ST_TOUT;
                  w_timeout_nxt   = 1'b1;
                  w_lock_nxt      = 1'b0;
                  w_mcnt_nxt      = '0;
                  w_have_prev_nxt = 1'b0;
               end
            end
         end

         ST_TOUT: begin
            if (w_rise) begin
               w_timeout_nxt = 1'b0;
               w_cnt_nxt     = CNT_ONE;
               w_hcnt_nxt    = CNT_ONE;
               w_state_nxt   = ST_MEAS;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign Period    = r_period;
   assign High_time = r_high;
   assign Valid     = r_valid;
   assign L         = r_lock;
   assign Timeout   = r_timeout;

endmodule
